// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and stage widths for the elastic pipeline buffers
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Payload widths of the four stage boundaries; wrappers pack/unpack fields to these.
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 147;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

endpackage

// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - elastic 2-entry pipeline stage register with registered ready and flush
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int                DATA_W            = IF_ID_W,
    parameter logic [DATA_W-1:0] NOP_VALUE         = {DATA_W{1'b0}},
    parameter bit                FLUSH_KEEPS_INPUT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    // in_ready depends only on state_q, so no ready path runs from downstream to upstream.
    assign in_ready  = (state_q != PIPE_FULL);
    assign out_valid = (state_q != PIPE_EMPTY);
    assign occupancy = state_q;
    assign out_data  = out_valid ? main_q : NOP_VALUE;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            PIPE_EMPTY: begin
                if (in_fire) begin
                    state_d = PIPE_ONE;
                    main_d  = in_data;
                end
            end
            PIPE_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = PIPE_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = PIPE_EMPTY;
                    main_d  = NOP_VALUE;
                end
            end
            PIPE_FULL: begin
                if (out_fire) begin
                    state_d = PIPE_ONE;
                    main_d  = skid_q;
                    skid_d  = NOP_VALUE;
                end
            end
            default: begin
                state_d = PIPE_EMPTY;
                main_d  = NOP_VALUE;
                skid_d  = NOP_VALUE;
            end
        endcase

        // An out_fire in the flush cycle has already been delivered; only held entries are squashed.
        if (flush) begin
            state_d = PIPE_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
            if (FLUSH_KEEPS_INPUT && in_fire) begin
                state_d = PIPE_ONE;
                main_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PIPE_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
